// File: rtl/m68k_bus_pkg.sv
// Shared codes for the 68040 bus initiator: TT/SIZ/TM encodings, response codes, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package m68k_bus_pkg;

  localparam logic [1:0] TT_NORMAL = 2'b00;

  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;
  localparam logic [1:0] SIZ_LINE = 2'b11;

  localparam logic [2:0] TM_USER_DATA = 3'b001;
  localparam logic [2:0] TM_SUPV_DATA = 3'b101;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_BUS     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_START,
    ST_DATA,
    ST_DONE
  } state_t;

endpackage

// File: rtl/m68k_bus_master_if.sv
// Request/response handshake plus 68040 bus pins for the bus initiator.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready on the agent side; nTA/nTEA pacing on the bus side.
interface m68k_bus_master_if;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         req_rw;
  logic [1:0]   req_siz;
  logic [127:0] req_wdata;
  logic         rsp_valid;
  logic [127:0] rsp_rdata;
  logic [1:0]   rsp_err;
  logic         nBR;
  logic         nBG;
  logic         BOWN;
  logic [31:0]  A;
  logic [1:0]   TT;
  logic [2:0]   TM;
  logic [1:0]   SIZ;
  logic         RW;
  logic         nTS;
  logic [31:0]  D_out;
  logic         D_oe;
  logic [31:0]  D_in;
  logic         nTA;
  logic         nTBI;
  logic         nTEA;

  modport master (
    input  req_valid, req_addr, req_rw, req_siz, req_wdata, nBG, D_in, nTA, nTBI, nTEA,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, nBR, BOWN, A, TT, TM, SIZ, RW, nTS,
           D_out, D_oe
  );

  modport slave (
    output req_valid, req_addr, req_rw, req_siz, req_wdata, nBG, D_in, nTA, nTBI, nTEA,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, nBR, BOWN, A, TT, TM, SIZ, RW, nTS,
           D_out, D_oe
  );
endinterface

// File: rtl/bus_timeout.sv
// Per-beat watchdog: loadable 8-bit down-counter, flags expiry when it reaches zero.
// Latency: load takes effect next cycle; expired is combinational from the count.
// Backpressure: none; counts only while enabled and saturates at zero.
module bus_timeout (
  input  logic       clk,
  input  logic       nRESET,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_en,
  output logic       o_expired
);

  logic [7:0] r_cnt;

  // Reload wins over counting; hold at zero once expired.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_cnt <= 8'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != 8'd0)) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_expired = (r_cnt == 8'd0);

endmodule

// File: rtl/m68k_bus_master.sv
// 68040 bus initiator: turns one agent request into a single, line-burst or split-line bus transfer.
// Latency: zero-wait slave with grant held, accept -> rsp_valid in 4 cycles, +1 per extra burst beat.
// Backpressure: req_ready only in IDLE; each beat waits on nTA/nTEA up to TIMEOUT_CYCLES.
module m68k_bus_master
  import m68k_bus_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [2:0] TM_VAL         = TM_SUPV_DATA
) (
  input logic             clk,
  input logic             nRESET,
  m68k_bus_master_if.master bus
);

  state_t       r_state, w_next;
  logic [31:0]  r_addr;
  logic         r_rw;
  logic [1:0]   r_siz;
  logic [127:0] r_wdata;
  logic [1:0]   r_beat, w_beat_nxt;
  logic         r_split, w_split_nxt;
  logic [127:0] r_rdata;
  logic [1:0]   r_err, w_err_val;
  logic         w_err_set, w_capture, w_tmo_load, w_tmo_expired;
  logic         w_accept, w_active, w_line;
  logic [1:0]   w_split_a32;
  logic [31:0]  w_addr;

  assign w_accept    = (r_state == ST_IDLE) && bus.req_valid;
  assign w_active    = (r_state == ST_START) || (r_state == ST_DATA);
  assign w_line      = (r_siz == SIZ_LINE);
  // Split beats walk the longwords of the line, wrapping inside it.
  assign w_split_a32 = r_addr[3:2] + r_beat;
  assign w_addr      = r_split ? {r_addr[31:4], w_split_a32, 2'b00} : r_addr;

  bus_timeout u_timeout (
    .clk        (clk),
    .nRESET     (nRESET),
    .i_load     (w_tmo_load),
    .i_load_val (8'(TIMEOUT_CYCLES - 1)),
    .i_en       (r_state == ST_DATA),
    .o_expired  (w_tmo_expired)
  );

  // State register plus latched request, beat tracking and response capture.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= ST_IDLE;
      r_addr  <= 32'd0;
      r_rw    <= 1'b1;
      r_siz   <= SIZ_LONG;
      r_wdata <= 128'd0;
      r_beat  <= 2'd0;
      r_split <= 1'b0;
      r_rdata <= 128'd0;
      r_err   <= ERR_OK;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= bus.req_addr;
        r_rw    <= bus.req_rw;
        r_siz   <= bus.req_siz;
        r_wdata <= bus.req_wdata;
        r_beat  <= 2'd0;
        r_split <= 1'b0;
        r_rdata <= 128'd0;
        r_err   <= ERR_OK;
      end else begin
        r_beat  <= w_beat_nxt;
        r_split <= w_split_nxt;
        if (w_err_set) r_err <= w_err_val;
        if (w_capture) r_rdata[{r_beat, 5'b00000} +: 32] <= bus.D_in;
      end
    end
  end

  // Next state: nTEA beats nTA, nTA beats timeout; nTBI only matters on beat 0 of a line.
  always_comb begin
    w_next      = r_state;
    w_beat_nxt  = r_beat;
    w_split_nxt = r_split;
    w_capture   = 1'b0;
    w_err_set   = 1'b0;
    w_err_val   = ERR_OK;
    w_tmo_load  = 1'b0;
    case (r_state)
      ST_IDLE:  if (bus.req_valid) w_next = ST_ARB;
      ST_ARB:   if (!bus.nBG) w_next = ST_START;
      ST_START: begin
        w_tmo_load = 1'b1;
        w_next     = ST_DATA;
      end
      ST_DATA: begin
        if (!bus.nTEA) begin
          w_err_set = 1'b1;
          w_err_val = ERR_BUS;
          w_next    = ST_DONE;
        end else if (!bus.nTA) begin
          w_capture = r_rw;
          if (w_line && !r_split && (r_beat == 2'd0) && !bus.nTBI) begin
            w_split_nxt = 1'b1;
            w_beat_nxt  = 2'd1;
            w_next      = ST_START;
          end else if (w_line && !r_split && (r_beat != 2'd3)) begin
            w_beat_nxt = r_beat + 2'd1;
            w_tmo_load = 1'b1;
          end else if (r_split && (r_beat != 2'd3)) begin
            w_beat_nxt = r_beat + 2'd1;
            w_next     = ST_START;
          end else begin
            w_next = ST_DONE;
          end
        end else if (w_tmo_expired) begin
          w_err_set = 1'b1;
          w_err_val = ERR_TIMEOUT;
          w_next    = ST_DONE;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = (r_state == ST_DONE);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
  assign bus.nBR       = !((r_state == ST_ARB) || w_active);
  assign bus.BOWN      = w_active;
  assign bus.A         = w_active ? w_addr : 32'd0;
  assign bus.TT        = TT_NORMAL;
  assign bus.TM        = TM_VAL;
  assign bus.SIZ       = (w_active && !r_split) ? r_siz : SIZ_LONG;
  assign bus.RW        = w_active ? r_rw : 1'b1;
  assign bus.nTS       = (r_state != ST_START);
  assign bus.D_oe      = w_active && !r_rw;
  assign bus.D_out     = bus.D_oe ? r_wdata[{r_beat, 5'b00000} +: 32] : 32'd0;

endmodule

// File: tb/tb_m68k_bus_master.sv
// Directed bench for m68k_bus_master with a reactive 68040 slave model and response scoreboard.
// Latency: checks the 4-cycle single-transfer turnaround and 7-cycle line burst.
// Backpressure: slave can ack, split, error or stay silent to exercise the timeout.
module tb_m68k_bus_master;
  import m68k_bus_pkg::*;

  typedef struct {
    logic [127:0] rdata;
    logic [1:0]   err;
    int           cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] a;
    logic [1:0]  siz;
    logic        rw;
    logic [31:0] dout;
  } ts_t;

  logic clk = 1'b0;
  logic nRESET = 1'b0;
  always #5 clk = ~clk;

  m68k_bus_master_if bif ();

  m68k_bus_master #(.TIMEOUT_CYCLES(8), .TM_VAL(3'b101)) dut (
    .clk    (clk),
    .nRESET (nRESET),
    .bus    (bif)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulses = 0;
  int drift = 0;
  int s_beat = 0;
  int tea_beat = -1;
  bit no_resp = 1'b0;
  bit tbi_split = 1'b0;
  logic [31:0] rd_data [4];
  logic [31:0] cur_a = 32'd0;
  int acc_cyc = 0;

  rsp_t exp_rsp[$];
  rsp_t got_rsp[$];
  ts_t  exp_ts[$];
  ts_t  got_ts[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model and monitor: act on the falling edge so values settle before the next rising edge.
  always @(negedge clk) begin
    if (bif.rsp_valid === 1'b1) begin
      got_rsp.push_back('{bif.rsp_rdata, bif.rsp_err, cyc});
      pulses++;
    end
    if (bif.nBR === 1'b1) s_beat = 0;
    if (bif.BOWN === 1'b1 && bif.nTS === 1'b0) begin
      got_ts.push_back('{bif.A, bif.SIZ, bif.RW, bif.D_out});
      cur_a = bif.A;
    end
    if (bif.BOWN === 1'b1 && bif.nTS === 1'b1 && bif.A !== cur_a) drift++;
    if (bif.BOWN === 1'b1 && bif.nTS === 1'b1 && !no_resp) begin
      bif.nTA  = 1'b0;
      bif.D_in = rd_data[s_beat & 3];
      bif.nTBI = (tbi_split && s_beat == 0) ? 1'b0 : 1'b1;
      bif.nTEA = (s_beat == tea_beat) ? 1'b0 : 1'b1;
      s_beat++;
    end else begin
      bif.nTA  = 1'b1;
      bif.nTEA = 1'b1;
      bif.nTBI = 1'b1;
      bif.D_in = 32'hx;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] addr, input logic rw, input logic [1:0] siz,
                      input logic [127:0] wdata);
    @(negedge clk);
    bif.req_addr  = addr;
    bif.req_rw    = rw;
    bif.req_siz   = siz;
    bif.req_wdata = wdata;
    bif.req_valid = 1'b1;
    acc_cyc = cyc;
    #1;
    chk("req_ready_idle", bif.req_ready, 1'b1);
    @(negedge clk);
    bif.req_valid = 1'b0;
  endtask

  // Pop one response and compare against the scoreboard head.
  task automatic expect_rsp(input string tag, input int lat);
    rsp_t g, e;
    int n = 0;
    while (got_rsp.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rsp_arrived"}, got_rsp.size() != 0, 1'b1);
    if (got_rsp.size() != 0 && exp_rsp.size() != 0) begin
      g = got_rsp.pop_front();
      e = exp_rsp.pop_front();
      chk({tag, "_rdata"}, g.rdata, e.rdata);
      chk({tag, "_err"}, g.err, e.err);
      if (lat >= 0) chk({tag, "_latency"}, g.cyc - acc_cyc, lat);
    end
  endtask

  task automatic expect_ts(input string tag);
    ts_t g, e;
    chk({tag, "_nts_count"}, got_ts.size(), exp_ts.size());
    while (got_ts.size() != 0 && exp_ts.size() != 0) begin
      g = got_ts.pop_front();
      e = exp_ts.pop_front();
      chk({tag, "_ts"}, {g.a, g.siz, g.rw, g.dout}, {e.a, e.siz, e.rw, e.dout});
    end
    got_ts.delete();
    exp_ts.delete();
  endtask

  initial begin
    int p0;
    int n;
    bif.req_valid = 1'b0;
    bif.req_addr  = 32'd0;
    bif.req_rw    = 1'b1;
    bif.req_siz   = SIZ_LONG;
    bif.req_wdata = 128'd0;
    bif.nBG  = 1'b0;
    bif.nTA  = 1'b1;
    bif.nTEA = 1'b1;
    bif.nTBI = 1'b1;
    bif.D_in = 32'd0;
    for (int i = 0; i < 4; i++) rd_data[i] = 32'd0;

    // Reset values.
    #3;
    chk("rst_ready", bif.req_ready, 1'b1);
    chk("rst_bus", {bif.rsp_valid, bif.rsp_err, bif.nBR, bif.BOWN, bif.TT, bif.SIZ, bif.RW,
                    bif.nTS, bif.D_oe}, {1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0});
    chk("rst_addr_data", {bif.A, bif.D_out, bif.rsp_rdata}, 192'd0);
    chk("rst_tm", bif.TM, 3'b101);
    @(negedge clk);
    nRESET = 1'b1;

    // 1: long read, zero-wait.
    rd_data[0] = 32'hDEADBEEF;
    exp_rsp.push_back('{128'hDEADBEEF, ERR_OK, 0});
    exp_ts.push_back('{32'h0000_1004, SIZ_LONG, 1'b1, 32'd0});
    p0 = pulses;
    send(32'h0000_1004, 1'b1, SIZ_LONG, 128'd0);
    expect_rsp("t1", 4);
    expect_ts("t1");
    @(negedge clk);
    chk("t1_one_pulse", pulses - p0, 1);

    // 2: line read, four back-to-back beats, address held.
    rd_data[0] = 32'h11111111; rd_data[1] = 32'h22222222;
    rd_data[2] = 32'h33333333; rd_data[3] = 32'h44444444;
    drift = 0;
    exp_rsp.push_back('{128'h44444444_33333333_22222222_11111111, ERR_OK, 0});
    exp_ts.push_back('{32'h0000_0108, SIZ_LINE, 1'b1, 32'd0});
    send(32'h0000_0108, 1'b1, SIZ_LINE, 128'd0);
    expect_rsp("t2", 7);
    expect_ts("t2");
    chk("t2_addr_held", drift, 0);

    // 3: line write split by nTBI on beat 0.
    tbi_split = 1'b1;
    exp_rsp.push_back('{128'd0, ERR_OK, 0});
    exp_ts.push_back('{32'h0000_0208, SIZ_LINE, 1'b0, 32'hA0});
    exp_ts.push_back('{32'h0000_020C, SIZ_LONG, 1'b0, 32'hA1});
    exp_ts.push_back('{32'h0000_0200, SIZ_LONG, 1'b0, 32'hA2});
    exp_ts.push_back('{32'h0000_0204, SIZ_LONG, 1'b0, 32'hA3});
    send(32'h0000_0208, 1'b0, SIZ_LINE, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    expect_rsp("t3", -1);
    expect_ts("t3");
    tbi_split = 1'b0;

    // 4: nTEA together with nTA on beat 2.
    tea_beat = 2;
    p0 = pulses;
    exp_rsp.push_back('{{64'd0, 32'h22222222, 32'h11111111}, ERR_BUS, 0});
    send(32'h0000_0300, 1'b1, SIZ_LINE, 128'd0);
    expect_rsp("t4", -1);
    repeat (2) @(negedge clk);
    chk("t4_one_pulse", pulses - p0, 1);
    chk("t4_nbr_released", bif.nBR, 1'b1);
    tea_beat = -1;
    got_ts.delete();

    // 5: silent slave on a write, then a normal read.
    no_resp = 1'b1;
    exp_rsp.push_back('{128'd0, ERR_TIMEOUT, 0});
    send(32'h0000_0500, 1'b0, SIZ_LONG, 128'h12345678);
    expect_rsp("t5", -1);
    chk("t5_released", {bif.BOWN, bif.D_oe, bif.nBR}, {1'b0, 1'b0, 1'b1});
    no_resp = 1'b0;
    got_ts.delete();
    rd_data[0] = 32'h0BADCAFE;
    exp_rsp.push_back('{128'h0BADCAFE, ERR_OK, 0});
    send(32'h0000_0040, 1'b1, SIZ_WORD, 128'd0);
    expect_rsp("t5b", 4);
    got_ts.delete();

    // 6: reset in the middle of a line write.
    no_resp = 1'b1;
    send(32'h0000_0600, 1'b0, SIZ_LINE, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    n = 0;
    while (!(bif.BOWN === 1'b1 && bif.nTS === 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_data", bif.BOWN, 1'b1);
    #2 nRESET = 1'b0;
    #1;
    chk("t6_rst_bus", {bif.req_ready, bif.rsp_valid, bif.nBR, bif.BOWN, bif.nTS, bif.D_oe, bif.RW,
                       bif.SIZ}, {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00});
    chk("t6_rst_addr_data", {bif.A, bif.D_out}, 64'd0);
    no_resp = 1'b0;
    p0 = pulses;
    @(negedge clk);
    nRESET = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_no_rsp", pulses - p0, 0);
    got_ts.delete();
    got_rsp.delete();
    exp_rsp.push_back('{128'd0, ERR_OK, 0});
    exp_ts.push_back('{32'h0000_0700, SIZ_LONG, 1'b0, 32'hCAFEF00D});
    send(32'h0000_0700, 1'b0, SIZ_LONG, 128'hCAFEF00D);
    expect_rsp("t6", 4);
    expect_ts("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
